// File: rtl/phys_free_list_if.sv
// Rename-side bundle for the physical register free list: allocate, release,
// retire/flush controls and status outputs.
interface phys_free_list_if #(
    parameter int PW = 6
);
    logic [3:0]    alloc_vld_i;
    logic          alloc_en_i;
    logic [PW-1:0] alloc_preg0_o;
    logic [PW-1:0] alloc_preg1_o;
    logic [PW-1:0] alloc_preg2_o;
    logic [PW-1:0] alloc_preg3_o;
    logic          alloc_stall_o;
    logic [3:0]    rel_vld_i;
    logic [PW-1:0] rel_preg0_i;
    logic [PW-1:0] rel_preg1_i;
    logic [PW-1:0] rel_preg2_i;
    logic [PW-1:0] rel_preg3_i;
    logic [2:0]    retire_cnt_i;
    logic          flush_i;
    logic [5:0]    free_cnt_o;
    logic          ovf_err_o;

    modport slave (
        input  alloc_vld_i, alloc_en_i, rel_vld_i,
        input  rel_preg0_i, rel_preg1_i, rel_preg2_i, rel_preg3_i,
        input  retire_cnt_i, flush_i,
        output alloc_preg0_o, alloc_preg1_o, alloc_preg2_o, alloc_preg3_o,
        output alloc_stall_o, free_cnt_o, ovf_err_o
    );

    modport master (
        output alloc_vld_i, alloc_en_i, rel_vld_i,
        output rel_preg0_i, rel_preg1_i, rel_preg2_i, rel_preg3_i,
        output retire_cnt_i, flush_i,
        input  alloc_preg0_o, alloc_preg1_o, alloc_preg2_o, alloc_preg3_o,
        input  alloc_stall_o, free_cnt_o, ovf_err_o
    );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical registers: W-wide allocate from head, W-wide
// compacted release at tail, and an architectural head for flush recovery.
module phys_free_list_lane #(
    parameter int DEPTH = 32,
    parameter int PW    = 6,
    parameter int IW    = 5,
    parameter int CW    = 3
) (
    input  logic                       vld_i,
    input  logic [IW-1:0]              base_i,
    input  logic [CW-1:0]              off_i,
    input  logic [DEPTH-1:0][PW-1:0]   mem_i,
    output logic [PW-1:0]              preg_o
);
    logic [IW-1:0] idx;

    assign idx    = base_i + IW'(off_i);
    assign preg_o = vld_i ? mem_i[idx] : '0;
endmodule

module phys_free_list #(
    parameter int NPREG = 64,
    parameter int NAREG = 32,
    parameter int DEPTH = NPREG - NAREG,
    parameter int W     = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    phys_free_list_if.slave bus
);
    localparam int PW   = $clog2(NPREG);
    localparam int IW   = $clog2(DEPTH);
    localparam int PTRW = IW + 1;
    localparam int CW   = $clog2(W + 1);

    logic [DEPTH-1:0][PW-1:0] mem_q, mem_d;
    logic [PTRW-1:0]          head_q, head_d;
    logic [PTRW-1:0]          tail_q, tail_d;
    logic [PTRW-1:0]          arch_q, arch_d;
    logic                     ovf_q, ovf_d;

    logic [W-1:0][PW-1:0]     rel_preg;
    logic [W-1:0][PW-1:0]     alloc_preg;
    logic [W-1:0][CW-1:0]     apre, rpre;
    logic [CW-1:0]            nreq, nrel;
    logic [PTRW-1:0]          free_cnt;
    logic [PTRW:0]            cnt_after;
    logic                     stall, fire, rel_ok;
    logic [IW-1:0]            widx;

    assign rel_preg = {bus.rel_preg3_i, bus.rel_preg2_i, bus.rel_preg1_i, bus.rel_preg0_i};

    // Exclusive prefix counts give each valid slot its compacted offset.
    always_comb begin
        nreq = '0;
        nrel = '0;
        apre = '0;
        rpre = '0;
        for (int i = 0; i < W; i++) begin
            apre[i] = nreq;
            rpre[i] = nrel;
            nreq    = nreq + CW'(bus.alloc_vld_i[i]);
            nrel    = nrel + CW'(bus.rel_vld_i[i]);
        end
    end

    genvar g;
    for (g = 0; g < W; g++) begin : g_lane
        phys_free_list_lane #(
            .DEPTH (DEPTH),
            .PW    (PW),
            .IW    (IW),
            .CW    (CW)
        ) u_lane (
            .vld_i  (bus.alloc_vld_i[g]),
            .base_i (head_q[IW-1:0]),
            .off_i  (apre[g]),
            .mem_i  (mem_q),
            .preg_o (alloc_preg[g])
        );
    end

    assign free_cnt  = tail_q - head_q;
    assign stall     = PTRW'(nreq) > free_cnt;
    assign fire      = bus.alloc_en_i & ~stall & ~bus.flush_i;
    // Releases are judged against the post-allocation count so a full list rejects.
    assign cnt_after = {1'b0, free_cnt} - (fire ? (PTRW+1)'(nreq) : '0) + (PTRW+1)'(nrel);
    assign rel_ok    = cnt_after <= (PTRW+1)'(DEPTH);

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        arch_d = arch_q + PTRW'(bus.retire_cnt_i);
        ovf_d  = ovf_q;
        widx   = '0;
        if (bus.flush_i) begin
            head_d = arch_d;
        end else if (fire) begin
            head_d = head_q + PTRW'(nreq);
        end
        if (rel_ok) begin
            for (int i = 0; i < W; i++) begin
                if (bus.rel_vld_i[i]) begin
                    widx        = tail_q[IW-1:0] + IW'(rpre[i]);
                    mem_d[widx] = rel_preg[i];
                end
            end
            tail_d = tail_q + PTRW'(nrel);
        end else begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PW'(NAREG + i);
            end
            head_q <= '0;
            arch_q <= '0;
            tail_q <= PTRW'(DEPTH);
            ovf_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            arch_q <= arch_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.alloc_preg0_o = alloc_preg[0];
    assign bus.alloc_preg1_o = alloc_preg[1];
    assign bus.alloc_preg2_o = alloc_preg[2];
    assign bus.alloc_preg3_o = alloc_preg[3];
    assign bus.alloc_stall_o = stall;
    assign bus.free_cnt_o    = free_cnt;
    assign bus.ovf_err_o     = ovf_q;
endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios plus random traffic against a
// queue-based model (free queue, in-flight queue, retired-releasable pool).
module tb_phys_free_list;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    phys_free_list_if bus();

    phys_free_list dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;
    int fl[$];
    int infl[$];
    int pool[$];
    bit m_ovf;
    logic [5:0] obs_preg[4];
    logic       obs_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        infl.delete();
        pool.delete();
        for (int i = 0; i < 32; i++) fl.push_back(32 + i);
        m_ovf = 1'b0;
    endtask

    task automatic drive(input logic [3:0] vld, input logic en, input logic [3:0] rv,
                         input int r0, input int r1, input int r2, input int r3,
                         input int ret, input logic fls);
        bus.alloc_vld_i  = vld;
        bus.alloc_en_i   = en;
        bus.rel_vld_i    = rv;
        bus.rel_preg0_i  = 6'(r0);
        bus.rel_preg1_i  = 6'(r1);
        bus.rel_preg2_i  = 6'(r2);
        bus.rel_preg3_i  = 6'(r3);
        bus.retire_cnt_i = 3'(ret);
        bus.flush_i      = fls;
    endtask

    task automatic sample();
        obs_preg[0] = bus.alloc_preg0_o;
        obs_preg[1] = bus.alloc_preg1_o;
        obs_preg[2] = bus.alloc_preg2_o;
        obs_preg[3] = bus.alloc_preg3_o;
        obs_stall   = bus.alloc_stall_o;
    endtask

    // One clock of traffic: check combinational outputs, advance the model, check state.
    task automatic cycle(input logic [3:0] vld, input logic en, input logic [3:0] rv,
                         input int r0, input int r1, input int r2, input int r3,
                         input int ret, input logic fls);
        int r[4];
        int nreq, nrel, k;
        bit stall, fire, ok;
        r = '{r0, r1, r2, r3};
        drive(vld, en, rv, r0, r1, r2, r3, ret, fls);
        #1;
        sample();
        nreq  = $countones(vld);
        nrel  = $countones(rv);
        stall = nreq > fl.size();
        chk("stall", obs_stall, stall);
        chk("free_pre", bus.free_cnt_o, fl.size());
        if (!stall) begin
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (vld[i]) begin
                    chk($sformatf("preg%0d", i), obs_preg[i], fl[k]);
                    k++;
                end else begin
                    chk($sformatf("preg%0d_idle", i), obs_preg[i], 0);
                end
            end
        end
        fire = en && !stall && !fls;
        ok   = (fl.size() - (fire ? nreq : 0) + nrel) <= 32;
        @(posedge clk);
        #1;
        if (fire) repeat (nreq) infl.push_back(fl.pop_front());
        if (ok) begin
            for (int i = 0; i < 4; i++) if (rv[i]) fl.push_back(r[i]);
        end else begin
            m_ovf = 1'b1;
        end
        repeat (ret) pool.push_back(infl.pop_front());
        if (fls) begin
            for (int i = infl.size() - 1; i >= 0; i--) fl.push_front(infl[i]);
            infl.delete();
        end
        chk("free_cnt", bus.free_cnt_o, fl.size());
        chk("ovf", bus.ovf_err_o, m_ovf);
    endtask

    // Reset with busy inputs: reset must win over every operation.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'($urandom), 1'b1, 4'($urandom), $urandom_range(0, 63), $urandom_range(0, 63),
              $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 4), 1'($urandom));
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_free", bus.free_cnt_o, 32);
        chk("rst_ovf", bus.ovf_err_o, 0);
        drive(4'b1111, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        #1;
        sample();
        chk("rst_stall", obs_stall, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_preg%0d", i), obs_preg[i], 32 + i);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int ret;
        logic [3:0] rv;
        logic [3:0] vld;
        int r[4];

        rst_n = 1'b0;
        drive(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);

        // Full-width allocation from reset
        do_reset();
        cycle(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("d019_preg%0d", i), obs_preg[i], 32 + i);
        chk("d019_free", bus.free_cnt_o, 28);

        // Sparse valid mask compacts onto consecutive entries
        do_reset();
        cycle(4'b1010, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        chk("d020_p0", obs_preg[0], 0);
        chk("d020_p1", obs_preg[1], 32);
        chk("d020_p2", obs_preg[2], 0);
        chk("d020_p3", obs_preg[3], 33);
        chk("d020_free", bus.free_cnt_o, 30);

        // Drain to 3 free, stall, then release unblocks
        do_reset();
        repeat (7) cycle(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        cycle(4'b0001, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        chk("d021_free3", bus.free_cnt_o, 3);
        cycle(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        chk("d021_stall", obs_stall, 1);
        chk("d021_hold", bus.free_cnt_o, 3);
        cycle(4'b1111, 1'b1, 4'b0011, 1, 2, 0, 0, 0, 1'b0);
        chk("d021_stall_pre_rel", obs_stall, 1);
        chk("d021_free5", bus.free_cnt_o, 5);
        cycle(4'b1111, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        chk("d021_unstall", obs_stall, 0);

        // Simultaneous 4-wide alloc and release at free=4
        cycle(4'b0001, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        chk("d022_free4", bus.free_cnt_o, 4);
        cycle(4'b1111, 1'b1, 4'b1111, 3, 4, 5, 6, 0, 1'b0);
        chk("d022_fire", obs_stall, 0);
        chk("d022_old0", obs_preg[0], 62);
        chk("d022_free", bus.free_cnt_o, 4);
        cycle(4'b1111, 1'b1, 4'b1111, 7, 8, 9, 10, 0, 1'b0);
        chk("d022_new0", obs_preg[0], 3);
        chk("d022_new3", obs_preg[3], 6);

        // Flush recovers speculative allocations past the retired ones
        do_reset();
        cycle(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        cycle(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        cycle(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 2, 1'b1);
        chk("d023_free", bus.free_cnt_o, 30);
        cycle(4'b0001, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        chk("d023_preg", obs_preg[0], 34);

        // Release into a full list overflows and sticks
        do_reset();
        cycle(4'b0000, 1'b0, 4'b0001, 5, 0, 0, 0, 0, 1'b0);
        chk("d024_ovf", bus.ovf_err_o, 1);
        chk("d024_free", bus.free_cnt_o, 32);
        repeat (3) cycle(4'b0011, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        chk("d024_sticky", bus.ovf_err_o, 1);
        do_reset();

        // Random legal traffic: releases come only from retired registers
        for (int n = 0; n < 400; n++) begin
            vld = 4'($urandom);
            ret = $urandom_range(0, (infl.size() < 4) ? infl.size() : 4);
            rv  = 4'($urandom);
            while ($countones(rv) > pool.size()) rv = rv & (rv - 4'd1);
            for (int i = 0; i < 4; i++) r[i] = rv[i] ? pool.pop_front() : int'($urandom_range(0, 63));
            cycle(vld, 1'($urandom_range(0, 3) != 0), rv, r[0], r[1], r[2], r[3], ret,
                  1'($urandom_range(0, 11) == 0));
        end

        drive(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NPREG, 64, physical registers
- NAREG, 32, architectural registers
- DEPTH, 32 (NPREG-NAREG), free-list entries
- W, 4, rename/release width
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, single clock
- rst_n_i, in, 1, synchronous active-low reset
- alloc_vld_i, in, 4, per-slot destination needs a physical register; bit i is the ard_vld of rename slot i
- alloc_en_i, in, 1, rename group advances this cycle
- alloc_preg0_o..alloc_preg3_o, out, 6 each, physical register allocated to slot 0..3
- alloc_stall_o, out, 1, not enough free registers for the requested group
- rel_vld_i, in, 4, per-slot release valid (retiring instruction's old mapping)
- rel_preg0_i..rel_preg3_i, in, 6 each, physical registers being freed
- retire_cnt_i, in, 3, number of allocations retired this cycle (0..4)
- flush_i, in, 1, misprediction/exception recovery
- free_cnt_o, out, 6, free registers available (0..32)
- ovf_err_o, out, 1, sticky release-overflow error

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH 6-bit entries with 6-bit head, tail and arch_head pointers (5-bit index plus wrap bit).
REQ-004 free_cnt_o SHALL equal (tail - head) mod 64, driven from registered state.
REQ-005 nreq SHALL equal popcount(alloc_vld_i).
- alloc_stall_o = (nreq > free_cnt_o), combinational.
REQ-006 Each slot i with alloc_vld_i[i]=1 SHALL receive mem[head + popcount(alloc_vld_i[i-1:0])] on alloc_preg<i>_o, combinationally in the same cycle.
- Slots with alloc_vld_i[i]=0 SHALL output 6'd0.
REQ-007 An allocation SHALL fire when alloc_en_i=1, alloc_stall_o=0 and flush_i=0; head then advances by nreq at the clock edge.
REQ-008 No pointer or state SHALL change for allocation when alloc_en_i=0, alloc_stall_o=1, or flush_i=1.
REQ-009 nrel SHALL equal popcount(rel_vld_i).
- Valid releases are written compacted in slot order to mem[tail], mem[tail+1], and so on.
- tail advances by nrel.
REQ-010 Registers released in cycle N SHALL NOT be allocatable before cycle N+1; allocation uses pre-release free_cnt_o.
REQ-011 A release SHALL be rejected when free_cnt_o - (allocation fired ? nreq : 0) + nrel > DEPTH.
- On rejection: no write, tail unchanged, ovf_err_o set to 1 at the next edge.
- ovf_err_o stays 1 until reset.
REQ-012 arch_head SHALL advance by retire_cnt_i every cycle.
- retire_cnt_i exceeding the number of allocations in flight is illegal and is not checked.
REQ-013 When flush_i=1, head SHALL load arch_head + retire_cnt_i, discarding all speculative allocations.
- Releases in the same cycle are still accepted.
REQ-014 Pointer arithmetic SHALL wrap modulo 64, with index modulo 32.
- Free count is derived only from pointer differences and never saturates.
REQ-015 A simultaneous allocation, release and retire SHALL all apply in one cycle: head += nreq, tail += nrel, arch_head += retire_cnt_i.

Reset
REQ-016 On a clock edge with rst_n_i=0 the block SHALL set:
- mem[i] = 32+i for i = 0..31
- head = 0, arch_head = 0, tail = 6'b100000
- free_cnt_o = 32, ovf_err_o = 0
REQ-017 Reset asserted mid-operation SHALL override alloc, release, retire and flush in that cycle; the next cycle SHALL show reset values.
REQ-018 While rst_n_i=0, alloc_stall_o and the alloc_preg outputs SHALL reflect reset state after the first edge. Downstream stages ignore them until reset is released.

Verification
REQ-019 After reset, alloc_vld_i=4'b1111 with alloc_en_i=1 -> outputs 32,33,34,35 and alloc_stall_o=0; the next cycle free_cnt_o=28.
REQ-020 After reset, alloc_vld_i=4'b1010 with alloc_en_i=1 -> alloc_preg1_o=32, alloc_preg3_o=33, alloc_preg0_o=alloc_preg2_o=0; the next cycle free_cnt_o=30.
REQ-021 With free_cnt_o=3 and alloc_vld_i=4'b1111 -> alloc_stall_o=1 and head held; releasing 2 registers -> the next cycle free_cnt_o=5 and alloc_stall_o=0.
REQ-022 With free_cnt_o=4, a 4-wide alloc plus a 4-wide release in the same cycle -> the alloc fires and the next-cycle free_cnt_o=4; the released registers appear only in later allocations, after wrap.
REQ-023 From reset:
- 8 allocations over 2 cycles, then retire_cnt_i=2 and flush_i=1 -> the next cycle free_cnt_o=30.
- The next 1-wide alloc returns 34.
REQ-024 From reset, a release of 1 register -> ovf_err_o=1 the next cycle, free_cnt_o stays 32, and ovf_err_o remains 1 until rst_n_i=0.
